sonar_scheduler: RTL

- Round-robin ping scheduler that shares one ultrasonic measurement engine (trigger/echo timer) between N_SENSORS single-wire sensors.
- Selects a sensor through the engine's Sig mux and fires one measurement.
- Waits for completion or timeout, publishes the echo time tagged with the sensor index, then enforces a crosstalk holdoff before the next ping.
- Sits between the measurement engine and the LED/distance display logic.

---
 rtl/sonar_scheduler_pkg.sv | 20 ++
 rtl/sonar_scheduler_rr_pick.sv | 32 +++
 rtl/sonar_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sonar_scheduler_pkg.sv
// Shared constants for the sonar ping scheduler: state encoding, echo-time width,
// timeout sentinel and the 50 MHz default wait/holdoff budgets.
package sonar_scheduler_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam int TIME_W_DEF = 20;

    // Wide enough for any engine width; truncated to TIME_W where it is used.
    localparam logic [63:0] TIME_SENTINEL = '1;

    // 30 ms echo timeout and 60 ms crosstalk holdoff at a 50 MHz clock.
    localparam int TIMEOUT_CYC_50M = 1_500_000;
    localparam int HOLDOFF_CYC_50M = 3_000_000;

endpackage

// File: rtl/sonar_scheduler_rr_pick.sv
// Round-robin picker: first set bit of en_mask at or above ptr, wrapping past the
// top index back to zero.
module sonar_scheduler_rr_pick #(
    parameter int N_SENSORS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [N_SENSORS-1:0] en_mask,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     cur,
    output logic                 found
);

    always_comb begin
        logic [N_SENSORS-1:0] rot;
        int                   pos;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        rot   = N_SENSORS'({en_mask, en_mask} >> ptr);
        pos   = 0;
        cur   = '0;
        found = 1'b0;
        // rot[k] is sensor (ptr+k) mod N; scanning downward leaves the lowest hit.
        for (int k = N_SENSORS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pos   = int'(ptr) + k;
            end
        end
        if (pos >= N_SENSORS) pos = pos - N_SENSORS;
        if (found) cur = IDX_W'(pos);
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ping scheduler sharing one trigger/echo engine between N_SENSORS
// sensors; publishes each echo time (or a timeout) tagged with its sensor index.
module sonar_scheduler
    import sonar_scheduler_pkg::*;
#(
    parameter int N_SENSORS   = 4,
    parameter int IDX_W       = 2,
    parameter int TIME_W      = TIME_W_DEF,
    parameter int CNT_W       = 22,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_50M,
    parameter int HOLDOFF_CYC = HOLDOFF_CYC_50M
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 run,
    input  logic [N_SENSORS-1:0] en_mask,
    output logic [IDX_W-1:0]     meas_sel,
    output logic                 meas_start,
    output logic                 meas_abort,
    input  logic                 meas_done,
    input  logic [TIME_W-1:0]    meas_time,
    output logic                 res_valid,
    output logic [IDX_W-1:0]     res_idx,
    output logic [TIME_W-1:0]    res_time,
    output logic                 res_timeout,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_SENSORS - 1);

    logic [2:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] pick_cur;
    logic             pick_found;
    logic [CNT_W-1:0] cnt;

    sonar_scheduler_rr_pick #(
        .N_SENSORS (N_SENSORS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .en_mask (en_mask),
        .ptr     (ptr),
        .cur     (pick_cur),
        .found   (pick_found)
    );

    // NOTE: the whole block is plain flops (no memories), so every register is reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cur         <= '0;
            cnt         <= '0;
            meas_sel    <= '0;
            meas_start  <= 1'b0;
            meas_abort  <= 1'b0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_time    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            meas_start <= 1'b0;
            meas_abort <= 1'b0;
            res_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run && pick_found) begin
                        cur      <= pick_cur;
                        meas_sel <= pick_cur;
                        busy     <= 1'b1;
                        state    <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    meas_start <= 1'b1;
                    cnt        <= '0;
                    state      <= ST_START;
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done landing on the terminal count still wins over the timeout.
                    if (meas_done) begin
                        res_time    <= meas_time;
                        res_idx     <= cur;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_HOLDOFF;
                    end else if (cnt == TIMEOUT_LAST) begin
                        meas_abort  <= 1'b1;
                        res_time    <= TIME_W'(TIME_SENTINEL);
                        res_idx     <= cur;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_HOLDOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLDOFF_LAST) begin
                        ptr   <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
